// File: rtl/uart_tx_fifo.sv
// Transmit-side frame FIFO with a launcher FSM that pulses the UART transmitter's start input
// and tracks its busy flag, flagging frames the transmitter never acknowledged.
module uart_tx_fifo #(
    parameter int unsigned FRAME_BITS   = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [FRAME_BITS-1:0]   wr_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    tx_start,
    output logic [FRAME_BITS-1:0]   tx_data,
    input  logic                    tx_status,
    output logic                    lost_frame
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(BUSY_TIMEOUT) + 1;

    typedef enum logic [1:0] {StIdle, StLaunch, StWaitBusy, StWaitDone} state_e;

    state_e                 state_q, state_d;
    logic [FRAME_BITS-1:0]  mem [DEPTH];
    logic [AW-1:0]          rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]          count_q;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [FRAME_BITS-1:0]  tx_data_q;
    logic                   overflow_q, tx_start_q, lost_q;
    logic                   push, pop, lost_d;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign lost_frame = lost_q;

    // full is the registered value, so a push into a full FIFO drops even if a pop occurs
    assign push = wr_en && !full;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        pop     = 1'b0;
        lost_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty && !tx_status) begin
                    pop     = 1'b1;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                tmo_d   = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (tx_status) begin
                    state_d = StWaitDone;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    // frame is dropped, not retried
                    if (tmo_d == TW'(BUSY_TIMEOUT - 1)) begin
                        lost_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StWaitDone: begin
                if (!tx_status) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            tmo_q      <= '0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
            tx_start_q <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            overflow_q <= wr_en && full;
            tx_start_q <= pop;
            lost_q     <= lost_d;
            count_q    <= count_q + CW'(push) - CW'(pop);
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                tx_data_q <= mem[rd_ptr_q];
            end
        end
    end

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized scoreboard bench for uart_tx_fifo: a queue-based reference model plus a
// transmitter model that acknowledges launches two cycles later (or never, to force timeouts).
module tb_uart_tx_fifo;

    localparam int unsigned FRAME_BITS   = 8;
    localparam int unsigned DEPTH        = 16;
    localparam int unsigned BUSY_TIMEOUT = 4;
    localparam int unsigned CW           = $clog2(DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  wr_en = 1'b0;
    logic [FRAME_BITS-1:0] wr_data = '0;
    logic                  tx_status = 1'b0;
    logic                  full, empty, overflow, tx_start, lost_frame;
    logic [CW-1:0]         count;
    logic [FRAME_BITS-1:0] tx_data;

    uart_tx_fifo #(
        .FRAME_BITS  (FRAME_BITS),
        .DEPTH       (DEPTH),
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_status (tx_status),
        .lost_frame(lost_frame)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [FRAME_BITS-1:0] mq[$];
    logic [FRAME_BITS-1:0] last_data = '0;
    logic                  prev_reset = 1'b1, prev_wr_en = 1'b0, prev_tx_status = 1'b0;
    logic [FRAME_BITS-1:0] prev_wr_data = '0;
    int lphase = 0, idle_from = 0, launch_cyc = 0, rise_cyc = 0, exp_lost = -1;

    // Transmitter model controls
    int rise_at = -1, fall_at = -1;
    bit busy_force = 0, ignore_mode = 0, rand_tx = 0;
    int frame_len = 186;
    int first_start = -1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: evaluates the edge that opened the current cycle, then compares DUT outputs.
    always @(negedge clk) begin : monitor
        int c;
        bit exp_start, exp_ovf, full_before, ign;
        int len;
        c = cyc;
        exp_start = 0;
        exp_ovf   = 0;
        if (prev_reset) begin
            mq.delete();
            lphase    = 0;
            idle_from = c;
            exp_lost  = -1;
            last_data = '0;
        end else begin
            full_before = (mq.size() == DEPTH);
            exp_start   = (lphase == 0) && (idle_from <= c - 1) && (mq.size() > 0)
                          && !prev_tx_status;
            exp_ovf     = prev_wr_en && full_before;
            if (tx_start) begin
                if (mq.size() == 0) check("start_on_empty", 1, 0);
                else last_data = mq.pop_front();
            end
            if (prev_wr_en && !full_before) mq.push_back(prev_wr_data);
        end
        check("tx_start", int'(tx_start), int'(exp_start));
        if (tx_start) check("tx_data_launch", int'(tx_data), int'(last_data));
        else check("tx_data_hold", int'(tx_data), int'(last_data));
        check("count", int'(count), mq.size());
        check("empty", int'(empty), int'(mq.size() == 0));
        check("full", int'(full), int'(mq.size() == DEPTH));
        check("overflow", int'(overflow), int'(exp_ovf));
        check("lost_frame", int'(lost_frame), int'(c == exp_lost));

        // Launcher progress, derived from the handshake timing rules
        if (tx_start) begin
            lphase     = 1;
            launch_cyc = c;
            if (first_start < 0) first_start = c;
            ign = ignore_mode;
            len = frame_len;
            if (rand_tx) begin
                ign = ($urandom_range(0, 9) == 0);
                len = $urandom_range(1, 20);
            end
            if (!ign) begin
                rise_at = c + 2;
                fall_at = c + 2 + len;
            end
        end else if (lphase == 1) begin
            if (tx_status) begin
                lphase   = 2;
                rise_cyc = c;
            end else if (c == launch_cyc + int'(BUSY_TIMEOUT) - 1) begin
                lphase    = 0;
                idle_from = c + 1;
                exp_lost  = c + 1;
            end
        end else if (lphase == 2 && c > rise_cyc && !tx_status) begin
            lphase    = 0;
            idle_from = c + 1;
        end

        prev_reset     = reset;
        prev_wr_en     = wr_en;
        prev_wr_data   = wr_data;
        prev_tx_status = tx_status;
    end

    task automatic step();
        @(posedge clk);
        #1;
        tx_status = busy_force || (cyc >= rise_at && cyc < fall_at);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            wr_en = 1'b0;
        end
    endtask

    task automatic push(input logic [FRAME_BITS-1:0] d);
        step();
        wr_en   = 1'b1;
        wr_data = d;
    endtask

    task automatic drain(input int bound);
        int i;
        wr_en = 1'b0;
        for (i = 0; i < bound && mq.size() != 0; i++) idle(1);
        check("drain", mq.size(), 0);
        idle(40);
    endtask

    initial begin
        int p;
        int rate;
        // Reset defaults
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(6);

        // Single frame: launch two cycles after the push
        push(8'hA5);
        p = cyc;
        idle(200);
        check("single_latency", first_start, p + 2);

        // Fill and overflow with the transmitter held busy
        busy_force = 1;
        for (int i = 0; i < 17; i++) push(FRAME_BITS'(i));
        idle(2);
        check("fill_count", int'(count), int'(DEPTH));
        busy_force = 0;
        frame_len  = 3;
        drain(2000);

        // Push in the same cycle as a pop
        busy_force = 1;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        busy_force = 0;
        step();
        wr_en   = 1'b1;
        wr_data = 8'h77;
        step();
        wr_en = 1'b0;
        check("simul_count", int'(count), 3);
        drain(2000);

        // Transmitter never acknowledges
        ignore_mode = 1;
        push(8'h3C);
        idle(20);
        check("timeout_empty", int'(empty), 1);
        ignore_mode = 0;

        // Reset while a frame is in flight
        frame_len = 60;
        for (int i = 0; i < 5; i++) push(FRAME_BITS'(8'hC0 + i));
        idle(8);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_mid_count", int'(count), 0);
        idle(80);

        // Randomized traffic
        rand_tx = 1;
        rate    = 40;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) rate = (i % 1500 == 0) ? 90 : ((i % 1000 == 0) ? 10 : 40);
            step();
            wr_en   = ($urandom_range(0, 99) < rate);
            wr_data = FRAME_BITS'($urandom);
            reset   = ($urandom_range(0, 799) == 0);
        end
        step();
        reset = 1'b0;
        drain(4000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
